keypad_entry_ctrl: RTL and testbench

KEYPAD_ENTRY_CTRL -- requirements
Module: keypad_entry_ctrl

---
 rtl/keypad_entry_ctrl_pkg.sv | 20 ++
 rtl/key_debouncer.sv | 94 +++++++++
 rtl/keypad_entry_ctrl.sv | 107 ++++++++++
 tb/tb_keypad_entry_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/keypad_entry_ctrl_pkg.sv
// Shared key-code constants, debouncer state encoding and key classification
// for the keypad entry controller.
package keypad_entry_ctrl_pkg;

   localparam logic [3:0] KEY_STAR      = 4'hA;
   localparam logic [3:0] KEY_HASH      = 4'hB;
   localparam logic [3:0] KEY_MAX_DIGIT = 4'h9;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      PRESS_DB   = 2'd1,
      HELD       = 2'd2,
      RELEASE_DB = 2'd3
   } press_state_t;

   function automatic logic is_digit(input logic [3:0] code);
      return (code <= KEY_MAX_DIGIT);
   endfunction

endpackage

// File: rtl/key_debouncer.sv
// Synchronizes the raw key level and debounces press and release; emits one
// accept pulse (with the sampled key code) each time a press is confirmed.
module key_debouncer #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic       ck,
   input  logic       reset_n,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   output logic       accept,
   output logic [3:0] code,
   output logic       idle
);
   import keypad_entry_ctrl_pkg::*;

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   press_state_t  state, state_next;
   logic [CW-1:0] cnt, cnt_next;
   logic          accept_next;
   logic          sync1, synced;

   // The first stable level is counted on the IDLE/HELD exit, so DEBOUNCE_CYCLES >= 2 is assumed.
   always_ff @(posedge ck or negedge reset_n) begin
      if (!reset_n) begin
         sync1  <= 1'b0;
         synced <= 1'b0;
         state  <= IDLE;
         cnt    <= '0;
         accept <= 1'b0;
         code   <= 4'h0;
      end else begin
         sync1  <= key_valid;
         synced <= sync1;
         state  <= state_next;
         cnt    <= cnt_next;
         accept <= accept_next;
         if (accept_next) begin
            code <= key_code;
         end
      end
   end

   always_comb begin
      state_next  = state;
      cnt_next    = cnt;
      accept_next = 1'b0;
      case (state)
         IDLE: begin
            if (synced) begin
               state_next = PRESS_DB;
               cnt_next   = CW'(1);
            end
         end
         PRESS_DB: begin
            if (!synced) begin
               state_next = IDLE;
               cnt_next   = '0;
            end else if (cnt == CNT_LAST) begin
               state_next  = HELD;
               cnt_next    = '0;
               accept_next = 1'b1;
            end else begin
               cnt_next = cnt + CW'(1);
            end
         end
         HELD: begin
            if (!synced) begin
               state_next = RELEASE_DB;
               cnt_next   = CW'(1);
            end
         end
         RELEASE_DB: begin
            if (synced) begin
               state_next = HELD;
               cnt_next   = '0;
            end else if (cnt == CNT_LAST) begin
               state_next = IDLE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt + CW'(1);
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   assign idle = (state == IDLE);

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Keypad entry controller: turns debounced key accepts into digit writes,
// compare/clear requests, overflow reporting and an idle auto-clear.
module keypad_entry_ctrl #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int MAX_DIGITS      = 6,
   parameter int TIMEOUT_CYCLES  = 1024
) (
   input  logic                  ck,
   input  logic                  reset_n,
   input  logic                  key_valid,
   input  logic [3:0]            key_code,
   output logic [3:0]            data,
   output logic [MAX_DIGITS-1:0] input_cs,
   output logic                  is_pressed,
   output logic                  compare,
   output logic                  clear_input,
   output logic [2:0]            digit_count,
   output logic                  overflow
);
   import keypad_entry_ctrl_pkg::*;

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [2:0]    MAX_CNT  = 3'(MAX_DIGITS);

   logic          accept;
   logic [3:0]    key;
   logic          fsm_idle;
   logic          write_pend;
   logic          star_pend;
   logic [TW-1:0] tmo_cnt;

   key_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debouncer (
      .ck       (ck),
      .reset_n  (reset_n),
      .key_valid(key_valid),
      .key_code (key_code),
      .accept   (accept),
      .code     (key),
      .idle     (fsm_idle)
   );

   // data is loaded one cycle ahead of the cell select so it is stable at the cs rising edge;
   // the '*' clear trails compare by one cycle so the two never overlap.
   always_ff @(posedge ck or negedge reset_n) begin
      if (!reset_n) begin
         data        <= 4'h0;
         input_cs    <= '0;
         is_pressed  <= 1'b0;
         compare     <= 1'b0;
         clear_input <= 1'b0;
         digit_count <= 3'd0;
         overflow    <= 1'b0;
         write_pend  <= 1'b0;
         star_pend   <= 1'b0;
         tmo_cnt     <= '0;
      end else begin
         is_pressed  <= 1'b0;
         compare     <= 1'b0;
         clear_input <= 1'b0;
         overflow    <= 1'b0;
         input_cs    <= '0;
         write_pend  <= 1'b0;
         star_pend   <= 1'b0;

         if (write_pend) begin
            input_cs    <= MAX_DIGITS'(1) << digit_count;
            digit_count <= digit_count + 3'd1;
         end
         if (star_pend) begin
            clear_input <= 1'b1;
            digit_count <= 3'd0;
         end

         // An accept restarts the idle timer and wins over a timeout in the same cycle.
         if (accept) begin
            is_pressed <= 1'b1;
            tmo_cnt    <= '0;
            if (is_digit(key)) begin
               if (digit_count < MAX_CNT) begin
                  data       <= key;
                  write_pend <= 1'b1;
               end else begin
                  overflow <= 1'b1;
               end
            end else if (key == KEY_STAR) begin
               compare   <= 1'b1;
               star_pend <= 1'b1;
            end else if (key == KEY_HASH) begin
               clear_input <= 1'b1;
               digit_count <= 3'd0;
            end
         end else if (!fsm_idle || digit_count == 3'd0 || write_pend || star_pend) begin
            tmo_cnt <= '0;
         end else if (tmo_cnt == TMO_LAST) begin
            tmo_cnt     <= '0;
            clear_input <= 1'b1;
            digit_count <= 3'd0;
         end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
         end
      end
   end

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Directed testbench for keypad_entry_ctrl with default parameters; a negedge
// monitor records pulse counts and timing, checks compare against hand-derived values.
module tb_keypad_entry_ctrl;

   logic       ck = 1'b0;
   logic       reset_n = 1'b0;
   logic       key_valid = 1'b0;
   logic [3:0] key_code = 4'h0;
   logic [3:0] data;
   logic [5:0] input_cs;
   logic       is_pressed;
   logic       compare;
   logic       clear_input;
   logic [2:0] digit_count;
   logic       overflow;

   int checks = 0;
   int failures = 0;

   keypad_entry_ctrl dut (
      .ck         (ck),
      .reset_n    (reset_n),
      .key_valid  (key_valid),
      .key_code   (key_code),
      .data       (data),
      .input_cs   (input_cs),
      .is_pressed (is_pressed),
      .compare    (compare),
      .clear_input(clear_input),
      .digit_count(digit_count),
      .overflow   (overflow)
   );

   always #5 ck = ~ck;

   int cyc = 0;
   always @(posedge ck) cyc++;

   int press_n = 0, over_n = 0, cmp_n = 0, clr_n = 0;
   int cs_events = 0, cs_cycles = 0, cs_multi = 0, cmp_clr_both = 0;
   int press_cyc = 0, over_cyc = 0, cmp_cyc = 0, clr_cyc = 0, cs_cyc = 0;
   logic [3:0] press_data = 4'h0, cs_data = 4'h0;
   logic [5:0] cs_val = 6'h0, prev_cs = 6'h0;

   // Pulse monitor sampled on the falling edge, away from DUT updates.
   always @(negedge ck) begin
      if (is_pressed) begin press_n++; press_cyc = cyc; press_data = data; end
      if (overflow) begin over_n++; over_cyc = cyc; end
      if (compare) begin cmp_n++; cmp_cyc = cyc; end
      if (clear_input) begin clr_n++; clr_cyc = cyc; end
      if (compare && clear_input) cmp_clr_both++;
      if (input_cs != 6'h0) begin
         cs_cycles++;
         cs_cyc  = cyc;
         cs_val  = input_cs;
         cs_data = data;
         if (prev_cs == 6'h0) cs_events++;
         if ($countones(input_cs) > 1) cs_multi++;
      end
      prev_cs = input_cs;
   end

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks++;
      if (observed != expected) begin
         failures++;
         $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge ck);
      #1;
   endtask

   task automatic applyStimulus(input logic [3:0] code, input int hold, input int gap);
      key_code  = code;
      key_valid = 1'b1;
      waitCycles(hold);
      key_valid = 1'b0;
      waitCycles(gap);
   endtask

   int p0, o0, c0, k0, e0, n0, r0, s0;
   bit done;

   initial begin
      waitCycles(2);
      checkOutput("rst_data", data, 0);
      checkOutput("rst_cs", input_cs, 0);
      checkOutput("rst_count", digit_count, 0);
      checkOutput("rst_pulses", {is_pressed, compare, clear_input, overflow}, 0);
      reset_n = 1'b1;
      waitCycles(3);

      // Single '5' held 20 cycles: one accept, one cs cycle on cell 0.
      p0 = press_n; n0 = cs_cycles;
      applyStimulus(4'h5, 20, 30);
      checkOutput("p5_press", press_n - p0, 1);
      checkOutput("p5_data", press_data, 5);
      checkOutput("p5_cs", cs_val, 1);
      checkOutput("p5_cs_width", cs_cycles - n0, 1);
      checkOutput("p5_cs_data", cs_data, 5);
      checkOutput("p5_cs_time", cs_cyc - press_cyc, 1);
      checkOutput("p5_count", digit_count, 1);

      // Bounce then stable: latency is 2 sync + 16 debounce + 1 output register.
      p0 = press_n;
      key_code = 4'h3;
      for (int i = 0; i < 10; i++) begin
         key_valid = (i % 2 == 0);
         waitCycles(3);
      end
      key_valid = 1'b1;
      s0 = cyc;
      waitCycles(30);
      key_valid = 1'b0;
      waitCycles(30);
      checkOutput("bounce_press", press_n - p0, 1);
      checkOutput("bounce_latency", press_cyc - s0, 19);
      checkOutput("bounce_count", digit_count, 2);

      // '#' clears at A+1.
      k0 = clr_n;
      applyStimulus(4'hB, 20, 30);
      checkOutput("hash_clear", clr_n - k0, 1);
      checkOutput("hash_time", clr_cyc - press_cyc, 0);
      checkOutput("hash_count", digit_count, 0);

      // Fill all six cells, then overflow on a seventh digit.
      for (int i = 0; i < 6; i++) begin
         applyStimulus(4'(i + 1), 40, 30);
         checkOutput("walk_cs", cs_val, 1 << i);
         checkOutput("walk_count", digit_count, i + 1);
      end
      o0 = over_n; e0 = cs_events;
      applyStimulus(4'h7, 20, 30);
      checkOutput("ovf_pulse", over_n - o0, 1);
      checkOutput("ovf_time", over_cyc - press_cyc, 0);
      checkOutput("ovf_no_cs", cs_events - e0, 0);
      checkOutput("ovf_count", digit_count, 6);

      // Unused code: only is_pressed.
      p0 = press_n; o0 = over_n; c0 = cmp_n; k0 = clr_n; e0 = cs_events;
      applyStimulus(4'hC, 20, 30);
      checkOutput("unused_press", press_n - p0, 1);
      checkOutput("unused_others", (over_n - o0) + (cmp_n - c0) + (clr_n - k0) + (cs_events - e0), 0);
      checkOutput("unused_count", digit_count, 6);

      // 1,2,3,4 then '*': compare at A+1, clear at A+2.
      applyStimulus(4'hB, 20, 30);
      for (int i = 1; i <= 4; i++) applyStimulus(4'(i), 20, 30);
      checkOutput("star_pre_count", digit_count, 4);
      c0 = cmp_n; k0 = clr_n;
      applyStimulus(4'hA, 20, 30);
      checkOutput("star_compare", cmp_n - c0, 1);
      checkOutput("star_cmp_time", cmp_cyc - press_cyc, 0);
      checkOutput("star_clear", clr_n - k0, 1);
      checkOutput("star_clr_time", clr_cyc - press_cyc, 1);
      checkOutput("star_count", digit_count, 0);

      // '9' then idle: 18 release cycles plus 1024 idle cycles to the clear pulse.
      key_code  = 4'h9;
      key_valid = 1'b1;
      waitCycles(25);
      key_valid = 1'b0;
      r0 = cyc;
      k0 = clr_n;
      done = 1'b0;
      for (int i = 0; i < 1200 && !done; i++) begin
         waitCycles(1);
         if (clr_n != k0) done = 1'b1;
      end
      checkOutput("tmo_seen", done, 1);
      checkOutput("tmo_time", clr_cyc - r0, 1042);
      checkOutput("tmo_count", digit_count, 0);
      k0 = clr_n;
      waitCycles(1200);
      checkOutput("tmo_empty_quiet", clr_n - k0, 0);

      // Reset during the third digit's cs pulse.
      applyStimulus(4'h1, 20, 30);
      applyStimulus(4'h2, 20, 30);
      key_code  = 4'h3;
      key_valid = 1'b1;
      done = 1'b0;
      for (int i = 0; i < 60 && !done; i++) begin
         waitCycles(1);
         if (input_cs != 6'h0) done = 1'b1;
      end
      checkOutput("rst_mid_cs_seen", input_cs, 6'b000100);
      reset_n = 1'b0;
      #1;
      checkOutput("rst_mid_cs", input_cs, 0);
      checkOutput("rst_mid_count", digit_count, 0);
      checkOutput("rst_mid_data", data, 0);
      checkOutput("rst_mid_pulses", {is_pressed, compare, clear_input, overflow}, 0);
      key_valid = 1'b0;
      waitCycles(3);
      p0 = press_n; o0 = over_n; c0 = cmp_n; k0 = clr_n; e0 = cs_events;
      reset_n = 1'b1;
      waitCycles(80);
      checkOutput("rst_after_pulses", (press_n - p0) + (over_n - o0) + (cmp_n - c0) + (clr_n - k0) + (cs_events - e0), 0);
      checkOutput("rst_after_count", digit_count, 0);

      checkOutput("cs_onehot", cs_multi, 0);
      checkOutput("cmp_clr_exclusive", cmp_clr_both, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
